// File: rtl/execute_ctrl_pkg.sv
// execute_ctrl_pkg: shared select encodings, shadow slot type and FSM states for the operand controller
package execute_ctrl_pkg;
  localparam int RD_W = 8;
  typedef enum logic [1:0] {OP2_REG = 2'b00, OP2_IMM = 2'b01, OP2_ONE = 2'b10, OP2_ZERO = 2'b11} op2_sel_t;
  typedef enum logic [1:0] {FWD_RF = 2'b00, FWD_EXMEM = 2'b01, FWD_MEMWB = 2'b10} fwd_sel_t;
  typedef struct packed {
    logic valid;
    logic [RD_W-1:0] rd;
    logic reg_write;
    logic is_load;
  } slot_t;
  typedef enum logic {RUN, STALL} state_t;
  localparam slot_t BUBBLE = '0;
  function automatic logic producer(slot_t s);
    return s.valid && s.reg_write && s.rd != '0;
  endfunction
endpackage

// File: rtl/execute_operand_controller_hazard_match.sv
// hazard_match: compares one decode source register against the EX and MEM shadow slots
module hazard_match import execute_ctrl_pkg::*; #(
  parameter int REG_ADDR_W = 5
) (
  input  logic [REG_ADDR_W-1:0] rs,
  input  logic                  uses,
  input  slot_t                 ex,
  input  slot_t                 mem,
  output logic                  matchEx,
  output logic                  matchMem,
  output logic                  loadMatchEx
);
  logic unused_mem_load;
  assign unused_mem_load = mem.is_load;
  assign matchEx = uses && producer(ex) && ex.rd == RD_W'(rs);
  assign matchMem = uses && producer(mem) && mem.rd == RD_W'(rs);
  assign loadMatchEx = matchEx && ex.is_load;
endmodule

// File: rtl/execute_operand_controller.sv
// execute_operand_controller: forwarding/operand-2 selects and hazard stall for EX; FORWARD_EN enables forwarding
module execute_operand_controller import execute_ctrl_pkg::*; #(
  parameter int REG_ADDR_W  = 5,
  parameter int STALL_CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   decValid,
  input  logic [REG_ADDR_W-1:0]  decRs1,
  input  logic [REG_ADDR_W-1:0]  decRs2,
  input  logic                   decUsesRs1,
  input  logic                   decUsesRs2,
  input  logic [REG_ADDR_W-1:0]  decRd,
  input  logic                   decRegWrite,
  input  logic                   decIsLoad,
  input  logic [1:0]             decOp2Sel,
  input  logic                   flush,
  output logic                   stall,
  output logic [1:0]             input2Select,
  output logic [1:0]             fwdSelA,
  output logic [1:0]             fwdSelB,
  output logic [STALL_CNT_W-1:0] stallCount
);
  slot_t ex_q, mem_q, wb_q;
  state_t state, next;
  logic mex_a, mmem_a, ld_a, mex_b, mmem_b, ld_b, raw, adv;
  logic [1:0] fwd_a, fwd_b;
  logic unused_wb;
  hazard_match #(.REG_ADDR_W(REG_ADDR_W)) u_rs1 (
    .rs(decRs1), .uses(decUsesRs1), .ex(ex_q), .mem(mem_q),
    .matchEx(mex_a), .matchMem(mmem_a), .loadMatchEx(ld_a)
  );
  hazard_match #(.REG_ADDR_W(REG_ADDR_W)) u_rs2 (
    .rs(decRs2), .uses(decUsesRs2), .ex(ex_q), .mem(mem_q),
    .matchEx(mex_b), .matchMem(mmem_b), .loadMatchEx(ld_b)
  );
  // WB needs no forwarding since the register file writes before it reads
  assign unused_wb = ^wb_q;
`ifdef FORWARD_EN
  assign raw = ld_a | ld_b;
  assign fwd_a = mex_a ? FWD_EXMEM : mmem_a ? FWD_MEMWB : FWD_RF;
  assign fwd_b = mex_b ? FWD_EXMEM : mmem_b ? FWD_MEMWB : FWD_RF;
`else
  assign raw = ld_a | ld_b | mex_a | mmem_a | mex_b | mmem_b;
  assign fwd_a = FWD_RF;
  assign fwd_b = FWD_RF;
`endif
  assign stall = decValid && !flush && raw;
  assign adv = decValid && !stall && !flush;
  always_comb begin
    next = (state == STALL && (!stall || flush)) ? RUN : (state == RUN && stall) ? STALL : state;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      ex_q <= BUBBLE;
      mem_q <= BUBBLE;
      wb_q <= BUBBLE;
      input2Select <= OP2_REG;
      fwdSelA <= FWD_RF;
      fwdSelB <= FWD_RF;
      stallCount <= '0;
      state <= RUN;
    end else begin
      wb_q <= mem_q;
      mem_q <= ex_q;
      ex_q <= adv ? '{valid: 1'b1, rd: RD_W'(decRd), reg_write: decRegWrite, is_load: decIsLoad} : BUBBLE;
      input2Select <= adv ? decOp2Sel : OP2_REG;
      fwdSelA <= adv ? fwd_a : FWD_RF;
      fwdSelB <= adv ? fwd_b : FWD_RF;
      stallCount <= stallCount + STALL_CNT_W'(next == STALL && !(&stallCount));
      state <= next;
    end
  end
endmodule

// File: tb/tb_execute_operand_controller.sv
// tb_execute_operand_controller: directed scoreboard bench for both FORWARD_EN builds
module tb_execute_operand_controller;
  import execute_ctrl_pkg::*;
  logic clk = 0, reset = 1;
  logic decValid = 0, decUsesRs1 = 0, decUsesRs2 = 0, decRegWrite = 0, decIsLoad = 0, flush = 0;
  logic [4:0] decRs1 = 0, decRs2 = 0, decRd = 0;
  logic [1:0] decOp2Sel = 0;
  logic stall;
  logic [1:0] input2Select, fwdSelA, fwdSelB;
  logic [15:0] stallCount;
  int checks = 0, failures = 0;
  typedef struct packed {logic [1:0] a, b, i;} exp_t;
  exp_t q[$];

  execute_operand_controller dut (
    .clk(clk), .reset(reset), .decValid(decValid), .decRs1(decRs1), .decRs2(decRs2),
    .decUsesRs1(decUsesRs1), .decUsesRs2(decUsesRs2), .decRd(decRd), .decRegWrite(decRegWrite),
    .decIsLoad(decIsLoad), .decOp2Sel(decOp2Sel), .flush(flush), .stall(stall),
    .input2Select(input2Select), .fwdSelA(fwdSelA), .fwdSelB(fwdSelB), .stallCount(stallCount)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step(input string tag, input logic v, input logic [4:0] r1, input logic u1,
                      input logic [4:0] r2, input logic u2, input logic [4:0] rd, input logic rw,
                      input logic ld, input logic [1:0] op2, input logic fl, input logic es,
                      input logic [1:0] ea, input logic [1:0] eb, input logic [1:0] ei);
    exp_t e;
    decValid = v; decRs1 = r1; decUsesRs1 = u1; decRs2 = r2; decUsesRs2 = u2;
    decRd = rd; decRegWrite = rw; decIsLoad = ld; decOp2Sel = op2; flush = fl;
    #1;
    chk({tag, " stall"}, 32'(stall), 32'(es));
    q.push_back('{ea, eb, ei});
    @(posedge clk);
    #1;
    e = q.pop_front();
    chk({tag, " fwdSelA"}, 32'(fwdSelA), 32'(e.a));
    chk({tag, " fwdSelB"}, 32'(fwdSelB), 32'(e.b));
    chk({tag, " input2Select"}, 32'(input2Select), 32'(e.i));
  endtask

  task automatic bub(input string tag);
    step(tag, 0, 0, 0, 0, 0, 0, 0, 0, OP2_REG, 0, 0, FWD_RF, FWD_RF, OP2_REG);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst stall", 32'(stall), 0);
    chk("rst input2Select", 32'(input2Select), 0);
    chk("rst fwdSelA", 32'(fwdSelA), 0);
    chk("rst fwdSelB", 32'(fwdSelB), 0);
    chk("rst stallCount", 32'(stallCount), 0);
    reset = 0;
`ifdef FORWARD_EN
    step("addi x5", 1, 1, 1, 0, 0, 5, 1, 0, OP2_IMM, 0, 0, FWD_RF, FWD_RF, OP2_IMM);
    step("add x6,x5", 1, 5, 1, 1, 1, 6, 1, 0, OP2_REG, 0, 0, FWD_EXMEM, FWD_RF, OP2_REG);
    step("and x10,x6,x5", 1, 6, 1, 5, 1, 10, 1, 0, OP2_REG, 0, 0, FWD_EXMEM, FWD_MEMWB, OP2_REG);
    step("addi x10,x10", 1, 10, 1, 0, 0, 10, 1, 0, OP2_IMM, 0, 0, FWD_EXMEM, FWD_RF, OP2_IMM);
    step("youngest x10", 1, 10, 1, 0, 0, 11, 1, 0, OP2_REG, 0, 0, FWD_EXMEM, FWD_RF, OP2_REG);
    bub("d1"); bub("d2"); bub("d3");
    step("lw x7", 1, 1, 1, 0, 0, 7, 1, 1, OP2_IMM, 0, 0, FWD_RF, FWD_RF, OP2_IMM);
    step("sub stall", 1, 1, 1, 7, 1, 8, 1, 0, OP2_REG, 0, 1, FWD_RF, FWD_RF, OP2_REG);
    step("sub go", 1, 1, 1, 7, 1, 8, 1, 0, OP2_REG, 0, 0, FWD_RF, FWD_MEMWB, OP2_REG);
    chk("loaduse stallCount", 32'(stallCount), 1);
    bub("d4"); bub("d5");
    step("lw x0", 1, 1, 1, 0, 0, 0, 1, 1, OP2_IMM, 0, 0, FWD_RF, FWD_RF, OP2_IMM);
    step("use x0", 1, 0, 1, 0, 1, 4, 1, 0, OP2_REG, 0, 0, FWD_RF, FWD_RF, OP2_REG);
    step("lw x9", 1, 1, 1, 0, 0, 9, 1, 1, OP2_IMM, 0, 0, FWD_RF, FWD_RF, OP2_IMM);
    step("flush use", 1, 9, 1, 0, 0, 4, 1, 0, OP2_IMM, 1, 0, FWD_RF, FWD_RF, OP2_REG);
    step("after flush", 1, 9, 1, 0, 0, 12, 1, 0, OP2_REG, 0, 0, FWD_MEMWB, FWD_RF, OP2_REG);
    step("const1", 1, 1, 1, 2, 1, 13, 1, 1, OP2_ONE, 0, 0, FWD_RF, FWD_RF, OP2_ONE);
    step("invalid dec", 0, 13, 1, 0, 0, 0, 0, 0, OP2_IMM, 0, 0, FWD_RF, FWD_RF, OP2_REG);
    bub("d6");
    chk("end stallCount", 32'(stallCount), 1);
`else
    step("addi x5", 1, 1, 1, 0, 0, 5, 1, 0, OP2_IMM, 0, 0, FWD_RF, FWD_RF, OP2_IMM);
    step("add stall1", 1, 5, 1, 5, 1, 6, 1, 0, OP2_REG, 0, 1, FWD_RF, FWD_RF, OP2_REG);
    step("add stall2", 1, 5, 1, 5, 1, 6, 1, 0, OP2_REG, 0, 1, FWD_RF, FWD_RF, OP2_REG);
    step("add go", 1, 5, 1, 5, 1, 6, 1, 0, OP2_REG, 0, 0, FWD_RF, FWD_RF, OP2_REG);
    chk("twocycle stallCount", 32'(stallCount), 2);
    bub("d1"); bub("d2");
    step("lw x7", 1, 1, 1, 0, 0, 7, 1, 1, OP2_IMM, 0, 0, FWD_RF, FWD_RF, OP2_IMM);
    step("or x3", 1, 1, 1, 2, 1, 3, 1, 0, OP2_REG, 0, 0, FWD_RF, FWD_RF, OP2_REG);
    step("use x7 stall", 1, 1, 1, 7, 1, 8, 1, 0, OP2_REG, 0, 1, FWD_RF, FWD_RF, OP2_REG);
    step("use x7 go", 1, 1, 1, 7, 1, 8, 1, 0, OP2_REG, 0, 0, FWD_RF, FWD_RF, OP2_REG);
    chk("onecycle stallCount", 32'(stallCount), 3);
    bub("d3"); bub("d4");
    step("addi x0", 1, 1, 1, 0, 0, 0, 1, 0, OP2_IMM, 0, 0, FWD_RF, FWD_RF, OP2_IMM);
    step("use x0", 1, 0, 1, 0, 1, 4, 1, 0, OP2_REG, 0, 0, FWD_RF, FWD_RF, OP2_REG);
    step("addi x9", 1, 1, 1, 0, 0, 9, 1, 0, OP2_IMM, 0, 0, FWD_RF, FWD_RF, OP2_IMM);
    step("flush use", 1, 9, 1, 0, 0, 4, 1, 0, OP2_IMM, 1, 0, FWD_RF, FWD_RF, OP2_REG);
    step("x9 mem stall", 1, 9, 1, 0, 0, 12, 1, 0, OP2_REG, 0, 1, FWD_RF, FWD_RF, OP2_REG);
    step("x9 go", 1, 9, 1, 0, 0, 12, 1, 0, OP2_REG, 0, 0, FWD_RF, FWD_RF, OP2_REG);
    chk("flush stallCount", 32'(stallCount), 4);
    step("const1", 1, 1, 1, 2, 1, 13, 1, 0, OP2_ONE, 0, 0, FWD_RF, FWD_RF, OP2_ONE);
    step("invalid dec", 0, 12, 1, 0, 0, 0, 0, 0, OP2_IMM, 0, 0, FWD_RF, FWD_RF, OP2_REG);
    bub("d5");
    chk("end stallCount", 32'(stallCount), 4);
`endif
    bub("d7"); bub("d8");
    step("lw x3", 1, 1, 1, 0, 0, 3, 1, 1, OP2_IMM, 0, 0, FWD_RF, FWD_RF, OP2_IMM);
    decValid = 1; decRs1 = 3; decUsesRs1 = 1; decRs2 = 0; decUsesRs2 = 0;
    decRd = 4; decRegWrite = 1; decIsLoad = 0; decOp2Sel = OP2_REG; flush = 0;
    #1;
    chk("pre-reset stall", 32'(stall), 1);
    reset = 1;
    @(posedge clk);
    #1;
    chk("midreset stall", 32'(stall), 0);
    chk("midreset input2Select", 32'(input2Select), 0);
    chk("midreset fwdSelA", 32'(fwdSelA), 0);
    chk("midreset stallCount", 32'(stallCount), 0);
    reset = 0;
    bub("post reset");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
